// File: rtl/mmio_read_select.sv
// Load-side MMIO decoder: returns DMEM, fast status/readback registers or
// handshaked SD/DDR2 read data, stalling the pipeline until the load completes.
module mmio_read_select #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] UNMAPPED_DATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        re,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [31:0] dmem_addr,
    output logic        dmem_re,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] sd_status,
    input  logic [31:0] ddr2_status,
    input  logic [15:0] led_val,
    input  logic [31:0] seg_val,
    output logic        sd_rd_req,
    input  logic [31:0] sd_rd_data,
    input  logic        sd_rd_valid,
    output logic        ddr2_rd_req,
    input  logic [31:0] ddr2_rd_data,
    input  logic        ddr2_rd_valid,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        DMEM_WAIT,
        SLOW_REQ,
        SLOW_WAIT,
        RESP
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sel_ddr_q, sel_ddr_d;
    logic        tmo_q, tmo_d;
    logic        unm_q, unm_d;

    logic        fast_hit, err_hit, sd_hit, ddr_hit;
    logic [31:0] fast_val;
    logic        tmo_set, unm_set, err_clr;
    logic        slow_valid;
    logic [31:0] slow_data;

    // Address decode on the low 15 bits; DMEM space never matches these.
    always_comb begin
        fast_hit = 1'b0;
        err_hit  = 1'b0;
        sd_hit   = 1'b0;
        ddr_hit  = 1'b0;
        fast_val = '0;
        case (addr[14:0])
            15'h4040: begin fast_hit = 1'b1; fast_val = sd_status;            end
            15'h4048: begin fast_hit = 1'b1; fast_val = ddr2_status;          end
            15'h4050: begin fast_hit = 1'b1; fast_val = seg_val;              end
            15'h4054: begin fast_hit = 1'b1; fast_val = {16'b0, led_val};     end
            15'h4058: begin
                fast_hit = 1'b1;
                err_hit  = 1'b1;
                fast_val = {30'b0, tmo_q, unm_q};
            end
            15'h4014: sd_hit  = 1'b1;
            15'h4030: ddr_hit = 1'b1;
            default:  ;
        endcase
    end

    assign slow_valid = sel_ddr_q ? ddr2_rd_valid : sd_rd_valid;
    assign slow_data  = sel_ddr_q ? ddr2_rd_data  : sd_rd_data;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        sel_ddr_d   = sel_ddr_q;
        tmo_set     = 1'b0;
        unm_set     = 1'b0;
        err_clr     = 1'b0;
        stall       = 1'b0;
        dmem_re     = 1'b0;
        sd_rd_req   = 1'b0;
        ddr2_rd_req = 1'b0;
        rdata_valid = 1'b0;

        case (state_q)
            IDLE: begin
                stall   = re;
                dmem_re = re & ~addr[14];
                if (re) begin
                    if (!addr[14]) begin
                        state_d = DMEM_WAIT;
                    end else if (fast_hit) begin
                        data_d  = fast_val;
                        err_clr = err_hit;
                        state_d = RESP;
                    end else if (sd_hit || ddr_hit) begin
                        sel_ddr_d = ddr_hit;
                        state_d   = SLOW_REQ;
                    end else begin
                        data_d  = UNMAPPED_DATA;
                        unm_set = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            DMEM_WAIT: begin
                stall   = 1'b1;
                data_d  = dmem_rdata;
                state_d = RESP;
            end
            SLOW_REQ: begin
                stall       = 1'b1;
                sd_rd_req   = ~sel_ddr_q;
                ddr2_rd_req = sel_ddr_q;
                cnt_d       = '0;
                state_d     = SLOW_WAIT;
            end
            SLOW_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 16'd1;
                // Valid is checked first so it wins over a same-cycle timeout.
                if (slow_valid) begin
                    data_d  = slow_data;
                    state_d = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    data_d  = UNMAPPED_DATA;
                    tmo_set = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rdata_valid = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear-on-read of the error register; a new error in the same cycle wins.
    assign tmo_d = (tmo_q & ~err_clr) | tmo_set;
    assign unm_d = (unm_q & ~err_clr) | unm_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            sel_ddr_q <= 1'b0;
            tmo_q     <= 1'b0;
            unm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            sel_ddr_q <= sel_ddr_d;
            tmo_q     <= tmo_d;
            unm_q     <= unm_d;
        end
    end

    assign rdata     = data_q;
    assign bus_err   = tmo_q | unm_q;
    assign dmem_addr = addr;

endmodule

// File: tb/tb_mmio_read_select.sv
// Self-checking bench for mmio_read_select: directed vector table, reset
// corner case and randomized loads against a transaction-level model.
module tb_mmio_read_select;

    localparam int unsigned TMO = 8;
    localparam logic [31:0] UNM = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        re;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [31:0] dmem_addr;
    logic        dmem_re;
    logic [31:0] dmem_rdata;
    logic [31:0] sd_status;
    logic [31:0] ddr2_status;
    logic [15:0] led_val;
    logic [31:0] seg_val;
    logic        sd_rd_req;
    logic [31:0] sd_rd_data;
    logic        sd_rd_valid;
    logic        ddr2_rd_req;
    logic [31:0] ddr2_rd_data;
    logic        ddr2_rd_valid;
    logic        bus_err;

    mmio_read_select #(.TIMEOUT_CYCLES(TMO), .UNMAPPED_DATA(UNM)) dut (
        .clk(clk), .rst(rst), .addr(addr), .re(re), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .dmem_addr(dmem_addr),
        .dmem_re(dmem_re), .dmem_rdata(dmem_rdata), .sd_status(sd_status),
        .ddr2_status(ddr2_status), .led_val(led_val), .seg_val(seg_val),
        .sd_rd_req(sd_rd_req), .sd_rd_data(sd_rd_data), .sd_rd_valid(sd_rd_valid),
        .ddr2_rd_req(ddr2_rd_req), .ddr2_rd_data(ddr2_rd_data),
        .ddr2_rd_valid(ddr2_rd_valid), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic        exp_bus  = 1'b0;
    logic [31:0] last_rd  = '0;
    logic        m_tmo    = 1'b0;
    logic        m_unm    = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] dval;
        int unsigned delay;
        logic [31:0] exp_rd;
        int unsigned lat;
        logic        err;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic [31:0] exp_rdata);
        chk({tag, ".stall"},  {31'b0, stall},       32'd0);
        chk({tag, ".rvalid"}, {31'b0, rdata_valid}, 32'd0);
        chk({tag, ".rdata"},  rdata,                exp_rdata);
        chk({tag, ".sdreq"},  {31'b0, sd_rd_req},   32'd0);
        chk({tag, ".ddrreq"}, {31'b0, ddr2_rd_req}, 32'd0);
        chk({tag, ".dmemre"}, {31'b0, dmem_re},     32'd0);
    endtask

    // One load from the re cycle (k=0) through the completion strobe (k=lat).
    task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] dval,
                           input int unsigned delay, input logic [31:0] exp_rd,
                           input int unsigned lat, input logic err_after);
        logic is_dm, is_sd, is_dd;
        int unsigned gap;
        is_dm = ~a[14];
        is_sd = (a[14:0] == 15'h4014);
        is_dd = (a[14:0] == 15'h4030);
        for (int unsigned k = 0; k <= lat; k++) begin
            addr          = a;
            re            = (k < lat) ? 1'b1 : 1'($urandom_range(0, 1));
            dmem_rdata    = (k == 1) ? dval : $urandom;
            sd_rd_valid   = is_sd ? (k == 2 + delay) : 1'($urandom_range(0, 1));
            sd_rd_data    = (is_sd && k == 2 + delay) ? dval : $urandom;
            ddr2_rd_valid = is_dd ? (k == 2 + delay) : 1'($urandom_range(0, 1));
            ddr2_rd_data  = (is_dd && k == 2 + delay) ? dval : $urandom;
            @(negedge clk);
            chk({tag, ".stall"},  {31'b0, stall},       {31'b0, k < lat});
            chk({tag, ".rvalid"}, {31'b0, rdata_valid}, {31'b0, k == lat});
            chk({tag, ".dmemre"}, {31'b0, dmem_re},     {31'b0, is_dm && k == 0});
            chk({tag, ".sdreq"},  {31'b0, sd_rd_req},   {31'b0, is_sd && k == 1});
            chk({tag, ".ddrreq"}, {31'b0, ddr2_rd_req}, {31'b0, is_dd && k == 1});
            chk({tag, ".daddr"},  dmem_addr,            a);
            if (k == 0)
                chk({tag, ".buserr0"}, {31'b0, bus_err}, {31'b0, exp_bus});
            if (k == lat) begin
                chk({tag, ".rdata"},  rdata,              exp_rd);
                chk({tag, ".buserr"}, {31'b0, bus_err},   {31'b0, err_after});
            end
            @(posedge clk); #1;
        end
        exp_bus = err_after;
        last_rd = exp_rd;
        gap = $urandom_range(0, 2);
        for (int unsigned g = 0; g < gap; g++) begin
            re            = 1'b0;
            addr          = $urandom;
            sd_rd_valid   = 1'($urandom_range(0, 1));
            ddr2_rd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_quiet({tag, ".gap"}, last_rd);
            chk({tag, ".gap.buserr"}, {31'b0, bus_err}, {31'b0, exp_bus});
            @(posedge clk); #1;
        end
    endtask

    // Transaction-level reference: result and latency from the address map.
    task automatic model(input logic [31:0] a, input logic [31:0] dval, input int unsigned delay,
                         output logic [31:0] rd, output int unsigned lat);
        if (!a[14]) begin
            rd = dval; lat = 2;
        end else if (a[14:0] == 15'h4040) begin
            rd = sd_status; lat = 1;
        end else if (a[14:0] == 15'h4048) begin
            rd = ddr2_status; lat = 1;
        end else if (a[14:0] == 15'h4050) begin
            rd = seg_val; lat = 1;
        end else if (a[14:0] == 15'h4054) begin
            rd = {16'b0, led_val}; lat = 1;
        end else if (a[14:0] == 15'h4058) begin
            rd = {30'b0, m_tmo, m_unm}; lat = 1;
            m_tmo = 1'b0; m_unm = 1'b0;
        end else if (a[14:0] == 15'h4014 || a[14:0] == 15'h4030) begin
            if (delay < TMO) begin
                rd = dval; lat = 3 + delay;
            end else begin
                rd = UNM; lat = 3 + TMO - 1; m_tmo = 1'b1;
            end
        end else begin
            rd = UNM; lat = 1; m_unm = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a, dval, rd;
        int unsigned delay, lat, cat;

        tbl[0]  = '{32'h0000_4054, 32'h0,         0,  32'h0000_A5A5, 1,  1'b0};
        tbl[1]  = '{32'h0000_0010, 32'h1234_5678, 0,  32'h1234_5678, 2,  1'b0};
        tbl[2]  = '{32'h0000_4014, 32'hCAFE_F00D, 4,  32'hCAFE_F00D, 7,  1'b0};
        tbl[3]  = '{32'h0000_4030, 32'h1111_2222, 99, 32'h0000_0000, 10, 1'b1};
        tbl[4]  = '{32'h0000_4058, 32'h0,         0,  32'h0000_0002, 1,  1'b0};
        tbl[5]  = '{32'h0000_4058, 32'h0,         0,  32'h0000_0000, 1,  1'b0};
        tbl[6]  = '{32'h0000_4060, 32'h0,         0,  32'h0000_0000, 1,  1'b1};
        tbl[7]  = '{32'h0000_4058, 32'h0,         0,  32'h0000_0001, 1,  1'b0};
        tbl[8]  = '{32'h0000_4040, 32'h0,         0,  32'h5D5D_0001, 1,  1'b0};
        tbl[9]  = '{32'h0000_4048, 32'h0,         0,  32'hDD20_0002, 1,  1'b0};
        tbl[10] = '{32'h0000_4050, 32'h0,         0,  32'h7E6D_3F06, 1,  1'b0};
        tbl[11] = '{32'h0000_4030, 32'h0BAD_BEEF, 7,  32'h0BAD_BEEF, 10, 1'b0};
        tbl[12] = '{32'h0000_4014, 32'h1357_9BDF, 0,  32'h1357_9BDF, 3,  1'b0};
        tbl[13] = '{32'hABCD_4014, 32'h2468_ACE0, 1,  32'h2468_ACE0, 4,  1'b0};
        tbl[14] = '{32'h0000_3FFC, 32'h0F0F_0F0F, 0,  32'h0F0F_0F0F, 2,  1'b0};
        tbl[15] = '{32'hFFFF_4044, 32'h0,         0,  32'h0000_0000, 1,  1'b1};
        tbl[16] = '{32'h0000_4058, 32'h0,         0,  32'h0000_0001, 1,  1'b0};
        tbl[17] = '{32'hABCD_0058, 32'h55AA_55AA, 0,  32'h55AA_55AA, 2,  1'b0};
        tbl[18] = '{32'h0000_4030, 32'hFEED_FACE, 8,  32'h0000_0000, 10, 1'b1};
        tbl[19] = '{32'h0000_4058, 32'h0,         0,  32'h0000_0002, 1,  1'b0};

        rst = 1'b1; re = 1'b0; addr = '0; dmem_rdata = '0;
        sd_status = 32'h5D5D_0001; ddr2_status = 32'hDD20_0002;
        seg_val = 32'h7E6D_3F06; led_val = 16'hA5A5;
        sd_rd_data = '0; sd_rd_valid = 1'b0; ddr2_rd_data = '0; ddr2_rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset", 32'h0);
        chk("reset.buserr", {31'b0, bus_err}, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i].a, tbl[i].dval, tbl[i].delay,
                    tbl[i].exp_rd, tbl[i].lat, tbl[i].err);

        // Reset while waiting on SD data, with an error bit set beforehand.
        run_txn("pre_rst", 32'h0000_4060, 32'h0, 0, UNM, 1, 1'b1);
        addr = 32'h0000_4014; re = 1'b1; sd_rd_valid = 1'b0; ddr2_rd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.wait_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst.after", 32'h0);
        chk("rst.after.buserr", {31'b0, bus_err}, 32'd0);
        @(posedge clk); #1;
        sd_rd_valid = 1'b1; sd_rd_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        sd_rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet("rst.late_valid", 32'h0);
            @(posedge clk); #1;
        end
        exp_bus = 1'b0; m_tmo = 1'b0; m_unm = 1'b0;

        for (int i = 0; i < 200; i++) begin
            sd_status   = $urandom;
            ddr2_status = $urandom;
            seg_val     = $urandom;
            led_val     = 16'($urandom);
            dval        = $urandom;
            delay       = $urandom_range(0, 10);
            cat         = $urandom_range(0, 9);
            case (cat)
                0:       a = $urandom & 32'hFFFF_BFFF;
                1:       a = {$urandom_range(0, 65535), 1'b0, 15'h4040};
                2:       a = {$urandom_range(0, 65535), 1'b1, 15'h4048};
                3:       a = 32'h0000_4050;
                4:       a = 32'h0000_4054;
                5, 6:    a = {$urandom_range(0, 65535), 1'b0, 15'h4058};
                7:       a = {$urandom_range(0, 65535), 1'b1, 15'h4014};
                8:       a = 32'h0000_4030;
                default: begin
                    do a = $urandom | 32'h0000_4000;
                    while (a[14:0] inside {15'h4040, 15'h4048, 15'h4050, 15'h4054,
                                           15'h4058, 15'h4014, 15'h4030});
                end
            endcase
            model(a, dval, delay, rd, lat);
            run_txn($sformatf("rnd%0d", i), a, dval, delay, rd, lat, m_tmo | m_unm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
